ccff_bitstream_loader: RTL and testbench
========================================

Name: ccff_bitstream_loader

Overview:
- Configuration-chain driver that sits directly upstream of the logic-block configuration chain and feeds its `ccff_head` input.
- Accepts bitstream bytes over a valid/ready handshake and serializes them LSB-first onto `ccff_head`.
- Drives a clock enable used to gate `prog_clk` to the chain, so the chain advances exactly one position per bit emitted.
- Stops after exactly CHAIN_LEN bits. Default 18 = one ble4: 16 LUT4 bits plus 2 output-mux bits.

Parameters:
- CHAIN_LEN, 18: total configuration bits in the downstream chain; must be ≥1.
- CNT_W, 16: width of the bit counter; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- prog_clk  in  1  programming clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; 0 = reset
- start  in  1  single-cycle request to begin a load
- bs_data  in  8  bitstream byte; bit 0 is shifted first
- bs_valid  in  1  bs_data is valid
- bs_ready  out  1  loader accepts bs_data this cycle
- ccff_head  out  1  serial configuration bit to the chain head
- chain_clk_en  out  1  chain captures ccff_head on this prog_clk edge
- busy  out  1  load in progress
- done  out  1  CHAIN_LEN bits delivered; held until next start
- bit_cnt  out  CNT_W  bits delivered in the current load

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; shift register sreg=0; nb (valid bits in sreg, 0..8)=0; bit_cnt=0; byte counter=0.
  - All outputs are 0.
  - Chain contents are undefined after a reset mid-load; a full reload is required.
- States: IDLE, LOAD, DONE.
- IDLE:
  - start=1 → LOAD. Clear bit_cnt, nb and byte counter.
- LOAD:
  - busy=1.
  - ccff_head = sreg[0], combinational from the register.
  - chain_clk_en = (nb≠0), combinational from registers.
  - On each edge with nb≠0: sreg shifts right by 1, nb decrements, bit_cnt increments.
  - bs_ready = (nb==0 || nb==1) && bytes_accepted < ceil(CHAIN_LEN/8).
  - Byte acceptance (bs_valid && bs_ready): sreg ← bs_data, nb ← 8. This has priority over the decrement. With a continuous stream this gives one bit per cycle and no bubbles.
  - Underrun (nb==0 and bs_valid=0): chain_clk_en=0; chain and counters hold; no error.
  - Edge where bit_cnt reaches CHAIN_LEN: → DONE, with nb cleared. Unused high bits of the final byte are discarded. If CHAIN_LEN mod 8 = r ≠ 0, only bits [r-1:0] of the last byte are used.
  - start while in LOAD: ignored.
- DONE:
  - done=1, busy=0, bs_ready=0, chain_clk_en=0, ccff_head=0.
  - bit_cnt holds at CHAIN_LEN.
  - start=1 → LOAD (restart): done clears on that edge.
- Output reset values: every output 0.
- Latency: first configuration bit is presented on the cycle after the byte is accepted. The total load takes CHAIN_LEN clock-enabled cycles plus any underrun stalls.
- chain_clk_en must never be 1 outside LOAD. The number of cycles with chain_clk_en=1 per load equals CHAIN_LEN exactly.
- Bits offered by the producer beyond ceil(CHAIN_LEN/8) bytes are not accepted (bs_ready stays 0).

Test Plan:
- Basic load, CHAIN_LEN=18:
  - Stimulus: start, then bytes 0xA5, 0x3C, 0xFE streamed with bs_valid held high.
  - Required: ccff_head sequence over enabled cycles = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 0,1.
  - Required: exactly 18 chain_clk_en cycles; done=1 on the cycle after the 18th; bit_cnt=18.
  - Required: bs_ready=0 after the third byte.
- Back-to-back throughput:
  - Stimulus: 3 bytes with bs_valid continuously high.
  - Required: chain_clk_en high for 18 consecutive cycles with no gaps.
- Underrun stall:
  - Stimulus: bs_valid dropped for 5 cycles after the first byte.
  - Required: chain_clk_en=0 and bit_cnt=8 throughout the gap; load resumes with the correct bit order and ends at 18.
- Partial last byte:
  - Stimulus: CHAIN_LEN=10, bytes 0xFF, 0x02.
  - Required: ccff_head = eight 1s, then 0, 1; bits 2-7 of 0x02 never clocked; done=1.
- Reset mid-load:
  - Stimulus: reset=0 asserted after 7 bits.
  - Required: immediately busy=0, chain_clk_en=0, bit_cnt=0.
  - Required: after release, start reloads the full 18 bits correctly.
- Start handling:
  - Stimulus: start pulsed during LOAD → ignored, and bit_cnt continues without interruption.
  - Stimulus: start in DONE → done=0 and busy=1 on the next cycle; a new 18-bit load completes.

Source files
------------

// File: rtl/ccff_bitstream_loader.sv
// Serializes bitstream bytes LSB-first onto the configuration chain head and
// gates the chain clock so the chain advances exactly CHAIN_LEN positions.
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 18,
    parameter int CNT_W     = 16
) (
    input  logic             prog_clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       bs_data,
    input  logic             bs_valid,
    output logic             bs_ready,
    output logic             ccff_head,
    output logic             chain_clk_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt
);
    localparam int NBYTES = (CHAIN_LEN + 7) / 8;
    localparam int BYTE_W = $clog2(NBYTES + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [BYTE_W-1:0] BYTES_MAX = BYTE_W'(NBYTES);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state, state_nxt;
    logic [7:0]        sreg, sreg_nxt;
    logic [3:0]        nb, nb_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [BYTE_W-1:0] byte_cnt, byte_nxt;

    always_ff @(posedge prog_clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sreg     <= '0;
            nb       <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
        end else begin
            state    <= state_nxt;
            sreg     <= sreg_nxt;
            nb       <= nb_nxt;
            bit_cnt  <= cnt_nxt;
            byte_cnt <= byte_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sreg_nxt     = sreg;
        nb_nxt       = nb;
        cnt_nxt      = bit_cnt;
        byte_nxt     = byte_cnt;
        bs_ready     = 1'b0;
        ccff_head    = 1'b0;
        chain_clk_en = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    sreg_nxt  = '0;
                    nb_nxt    = '0;
                    cnt_nxt   = '0;
                    byte_nxt  = '0;
                end
            end
            LOAD: begin
                busy         = 1'b1;
                ccff_head    = sreg[0];
                chain_clk_en = (nb != 4'd0);
                // Refill while the last bit is still going out keeps the stream gap-free
                bs_ready     = (nb <= 4'd1) && (byte_cnt < BYTES_MAX);
                if (chain_clk_en) begin
                    sreg_nxt = {1'b0, sreg[7:1]};
                    nb_nxt   = nb - 4'd1;
                    cnt_nxt  = bit_cnt + CNT_W'(1);
                end
                if (bs_valid && bs_ready) begin
                    sreg_nxt = bs_data;
                    nb_nxt   = 4'd8;
                    byte_nxt = byte_cnt + BYTE_W'(1);
                end
                // Leftover high bits of a partial last byte are dropped here
                if (chain_clk_en && bit_cnt == LAST_BIT) begin
                    state_nxt = DONE;
                    nb_nxt    = '0;
                    sreg_nxt  = '0;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nxt = LOAD;
                    sreg_nxt  = '0;
                    nb_nxt    = '0;
                    cnt_nxt   = '0;
                    byte_nxt  = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: directed vector table plus random-valid loads
// compared against a bit-queue model; covers CHAIN_LEN=18 and CHAIN_LEN=10.
module tb_ccff_bitstream_loader;
    localparam int CW = 16;

    logic          prog_clk = 1'b0;
    logic          reset    = 1'b0;
    logic          start18  = 1'b0;
    logic          start10  = 1'b0;
    logic          bs_valid = 1'b0;
    logic [7:0]    bs_data  = 8'h00;
    logic          r18, h18, e18, b18, d18;
    logic          r10, h10, e10, b10, d10;
    logic [CW-1:0] c18, c10;

    bit            sel10 = 1'b0;
    logic          cur_ready, cur_head, cur_en, cur_busy, cur_done;
    logic [CW-1:0] cur_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    ccff_bitstream_loader #(.CHAIN_LEN(18), .CNT_W(CW)) u_dut18 (
        .prog_clk(prog_clk), .reset(reset), .start(start18), .bs_data(bs_data),
        .bs_valid(bs_valid), .bs_ready(r18), .ccff_head(h18), .chain_clk_en(e18),
        .busy(b18), .done(d18), .bit_cnt(c18));

    ccff_bitstream_loader #(.CHAIN_LEN(10), .CNT_W(CW)) u_dut10 (
        .prog_clk(prog_clk), .reset(reset), .start(start10), .bs_data(bs_data),
        .bs_valid(bs_valid), .bs_ready(r10), .ccff_head(h10), .chain_clk_en(e10),
        .busy(b10), .done(d10), .bit_cnt(c10));

    always #5 prog_clk = ~prog_clk;

    always_comb begin
        cur_ready = sel10 ? r10 : r18;
        cur_head  = sel10 ? h10 : h18;
        cur_en    = sel10 ? e10 : e18;
        cur_busy  = sel10 ? b10 : b18;
        cur_done  = sel10 ? d10 : d18;
        cur_cnt   = sel10 ? c10 : c18;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: the chain sees the byte stream as one LSB-first bit queue, cut at len.
    function automatic logic [17:0] model_bits(input logic [23:0] bytes, input int nbytes, input int len);
        bit q[$];
        logic [17:0] r;
        logic [7:0] b;
        r = '0;
        for (int k = 0; k < nbytes; k++) begin
            b = bytes[8*k +: 8];
            for (int j = 0; j < 8; j++) q.push_back(b[j]);
        end
        for (int i = 0; i < len && q.size() > 0; i++) r[i] = q.pop_front();
        return r;
    endfunction

    task automatic run_load(input string name, input bit is10, input logic [23:0] bytes,
                            input int nbytes, input int stall_after, input int stall_cyc,
                            input bit rnd, input bit mid_start, input logic [17:0] exp);
        int len, need, accepted, cyc, first_en, last_en, en_cnt, stall_done, done_cyc;
        bit gap_ok, rdy_late, en_outside, want;
        logic [7:0]  q[$];
        logic [17:0] got, mask;
        len = is10 ? 10 : 18;
        need = (len + 7) / 8;
        mask = (18'h1 << len) - 18'h1;
        accepted = 0; cyc = 0; first_en = -1; last_en = -1; en_cnt = 0;
        stall_done = 0; done_cyc = -1;
        gap_ok = 1; rdy_late = 0; en_outside = 0; got = '0;
        for (int k = 0; k < nbytes; k++) q.push_back(bytes[8*k +: 8]);
        sel10 = is10;
        if (is10) start10 = 1'b1; else start18 = 1'b1;
        @(negedge prog_clk);
        start10 = 1'b0; start18 = 1'b0;
        check({name, "_start_busy"}, 32'(cur_busy), 32'd1);
        check({name, "_start_done"}, 32'(cur_done), 32'd0);
        while (done_cyc < 0 && cyc < 300) begin
            if (cur_en) begin
                if (en_cnt < 18) got[en_cnt] = cur_head;
                en_cnt++;
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
                if (!cur_busy) en_outside = 1;
            end
            if (accepted >= need && cur_ready) rdy_late = 1;
            if (cur_done) done_cyc = cyc;
            start10 = 1'b0; start18 = 1'b0;
            if (mid_start && cyc == 6) begin
                if (is10) start10 = 1'b1; else start18 = 1'b1;
            end
            want = (q.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
            if (stall_after >= 0 && accepted == stall_after + 1 && stall_done < stall_cyc) begin
                want = 0;
                if (cur_cnt == CW'(8 * accepted)) begin
                    stall_done++;
                    if (cur_en) gap_ok = 0;
                end
            end
            bs_valid = want;
            if (want) bs_data = q[0];
            else bs_data = 8'($urandom);
            if (want && cur_ready) begin
                void'(q.pop_front());
                accepted++;
            end
            @(negedge prog_clk);
            cyc++;
        end
        bs_valid = 1'b0; start10 = 1'b0; start18 = 1'b0;
        check({name, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
        check({name, "_en_count"}, 32'(en_cnt), 32'(len));
        check({name, "_bits"}, 32'(got & mask), 32'(exp & mask));
        check({name, "_done_latency"}, 32'(done_cyc), 32'(last_en + 1));
        check({name, "_bit_cnt"}, 32'(cur_cnt), 32'(len));
        check({name, "_busy_end"}, 32'(cur_busy), 32'd0);
        check({name, "_ready_after_last"}, 32'(rdy_late), 32'd0);
        check({name, "_bytes_taken"}, 32'(accepted), 32'(need));
        check({name, "_en_outside_load"}, 32'(en_outside), 32'd0);
        if (!rnd && stall_after < 0)
            check({name, "_contiguous"}, 32'(last_en - first_en + 1), 32'(len));
        if (stall_after >= 0) begin
            check({name, "_stall_cycles"}, 32'(stall_done), 32'(stall_cyc));
            check({name, "_stall_no_en"}, 32'(gap_ok), 32'd1);
        end
        @(negedge prog_clk);
        check({name, "_done_hold"}, 32'({cur_done, cur_en, cur_head, cur_ready}), 32'b1000);
    endtask

    typedef struct {
        logic [23:0] data;
        int          nbytes;
        bit          is10;
        int          stall_after;
        int          stall_cyc;
        bit          mid_start;
        logic [17:0] exp;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int cyc;
        logic [23:0] rb;
        tbl[0] = '{{8'hFE, 8'h3C, 8'hA5}, 3, 1'b0, -1, 0, 1'b0, {2'b10, 8'h3C, 8'hA5}};
        tbl[1] = '{{8'hFE, 8'h3C, 8'hA5}, 3, 1'b0,  0, 5, 1'b0, {2'b10, 8'h3C, 8'hA5}};
        tbl[2] = '{{8'h00, 8'h02, 8'hFF}, 2, 1'b1, -1, 0, 1'b0, 18'h002FF};
        tbl[3] = '{{8'hFE, 8'h3C, 8'hA5}, 3, 1'b0, -1, 0, 1'b1, {2'b10, 8'h3C, 8'hA5}};
        tbl[4] = '{{8'h01, 8'hFF, 8'h00}, 3, 1'b0, -1, 0, 1'b0, {2'b01, 8'hFF, 8'h00}};

        #12;
        check("reset_outputs18", 32'({r18, h18, e18, b18, d18}), 32'd0);
        check("reset_cnt18", 32'(c18), 32'd0);
        check("reset_outputs10", 32'({r10, h10, e10, b10, d10}), 32'd0);
        @(negedge prog_clk);
        reset = 1'b1;
        @(negedge prog_clk);
        check("idle_after_reset", 32'({r18, e18, b18, d18}), 32'd0);

        for (int i = 0; i < 5; i++)
            run_load($sformatf("v%0d", i), tbl[i].is10, tbl[i].data, tbl[i].nbytes,
                     tbl[i].stall_after, tbl[i].stall_cyc, 1'b0, tbl[i].mid_start, tbl[i].exp);

        // Reset mid-load after seven bits have gone out
        sel10 = 1'b0;
        start18 = 1'b1;
        @(negedge prog_clk);
        start18 = 1'b0;
        bs_valid = 1'b1;
        bs_data = 8'h5A;
        cyc = 0;
        while (c18 != CW'(7) && cyc < 50) begin
            @(negedge prog_clk);
            cyc++;
        end
        check("midrst_reach7", 32'(cyc < 50), 32'd1);
        #2 reset = 1'b0;
        bs_valid = 1'b0;
        #1;
        check("midrst_busy", 32'(b18), 32'd0);
        check("midrst_en", 32'(e18), 32'd0);
        check("midrst_cnt", 32'(c18), 32'd0);
        @(negedge prog_clk);
        reset = 1'b1;
        @(negedge prog_clk);
        run_load("after_rst", 1'b0, tbl[0].data, 3, -1, 0, 1'b0, 1'b0, tbl[0].exp);

        for (int i = 0; i < 8; i++) begin
            bit t10;
            t10 = (i % 2) == 1;
            rb = {8'($urandom), 8'($urandom), 8'($urandom)};
            run_load($sformatf("rnd%0d", i), t10, rb, 3, -1, 0, 1'b1, 1'b0,
                     model_bits(rb, 3, t10 ? 10 : 18));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
